// File: rtl/ccu_snoop_broadcaster_pkg.sv
// ccu_snoop_broadcaster_pkg: CRRESP bit indices and snoop broadcaster state encoding
package ccu_snoop_broadcaster_pkg;
  localparam int unsigned CR_DT  = 0;
  localparam int unsigned CR_ERR = 1;
  localparam int unsigned CR_PD  = 2;
  localparam int unsigned CR_IS  = 3;
  localparam int unsigned CR_WU  = 4;
  typedef enum logic [1:0] {SNP_IDLE, SNP_SNOOP, SNP_RESP, SNP_DATA} snp_bcast_state_e;
endpackage

// File: rtl/ccu_snoop_broadcaster.sv
// ccu_snoop_broadcaster: fans one snoop out to all non-initiating masters, merges CR, forwards one CD line
module ccu_snoop_broadcaster
  import ccu_snoop_broadcaster_pkg::*;
#(
  parameter int unsigned NoMstPorts      = 4,
  parameter int unsigned AddrWidth       = 64,
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned DcacheLineWidth = 128,
  parameter int unsigned IdxW            = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 snp_valid_i,
  output logic                                 snp_ready_o,
  input  logic [AddrWidth-1:0]                 snp_addr_i,
  input  logic [3:0]                           snp_type_i,
  input  logic [2:0]                           snp_prot_i,
  input  logic [IdxW-1:0]                      snp_init_i,
  output logic [NoMstPorts-1:0]                ac_valid_o,
  input  logic [NoMstPorts-1:0]                ac_ready_i,
  output logic [AddrWidth-1:0]                 ac_addr_o,
  output logic [3:0]                           ac_snoop_o,
  output logic [2:0]                           ac_prot_o,
  input  logic [NoMstPorts-1:0]                cr_valid_i,
  output logic [NoMstPorts-1:0]                cr_ready_o,
  input  logic [NoMstPorts-1:0][4:0]           cr_resp_i,
  input  logic [NoMstPorts-1:0]                cd_valid_i,
  output logic [NoMstPorts-1:0]                cd_ready_o,
  input  logic [NoMstPorts-1:0][DataWidth-1:0] cd_data_i,
  input  logic [NoMstPorts-1:0]                cd_last_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [4:0]                           res_resp_o,
  output logic [IdxW-1:0]                      res_src_o,
  output logic                                 data_valid_o,
  input  logic                                 data_ready_i,
  output logic [DataWidth-1:0]                 data_o,
  output logic                                 data_last_o
);
  localparam int unsigned Beats = DcacheLineWidth / DataWidth;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  snp_bcast_state_e state;
  logic [NoMstPorts-1:0] ac_pend, cr_pend, cd_pend, tgt_mask, cr_hs, cr_dt, cd_hs, cd_done, sel;
  logic [4:0] resp, cr_or;
  logic [IdxW-1:0] src, lowest;
  logic [CntW-1:0] cnt;
  logic cnt_last, fwd_hs;
  logic [AddrWidth-1:0] addr;
  logic [3:0] snoop;
  logic [2:0] prot;
  assign snp_ready_o  = state == SNP_IDLE;
  assign ac_valid_o   = state == SNP_SNOOP ? ac_pend : '0;
  assign cr_ready_o   = state == SNP_SNOOP ? cr_pend & ~ac_pend : '0;
  assign res_valid_o  = state == SNP_RESP;
  assign res_resp_o   = resp;
  assign res_src_o    = src;
  assign ac_addr_o    = addr;
  assign ac_snoop_o   = snoop;
  assign ac_prot_o    = prot;
  assign cnt_last     = cnt == CntW'(Beats - 1);
  assign data_valid_o = state == SNP_DATA && |(sel & cd_pend & cd_valid_i);
  assign data_last_o  = data_valid_o && cnt_last;
  assign fwd_hs       = data_valid_o && data_ready_i;
  assign cr_hs        = cr_valid_i & cr_ready_o;
  assign cd_hs        = cd_valid_i & cd_ready_o;
  // The forwarded port retires on its last counted beat even if cd_last is late or missing
  assign cd_done      = cd_hs & (cd_last_i | (sel & {NoMstPorts{cnt_last}}));
  // Descending scan leaves the lowest pending supplier in 'lowest'
  always_comb begin
    tgt_mask   = '0;
    sel        = '0;
    cr_dt      = '0;
    cr_or      = '0;
    lowest     = '0;
    data_o     = '0;
    cd_ready_o = '0;
    for (int i = NoMstPorts - 1; i >= 0; i--) begin
      tgt_mask[i]   = snp_init_i != IdxW'(i);
      sel[i]        = src == IdxW'(i);
      cr_dt[i]      = cr_resp_i[i][CR_DT];
      cr_or         = cr_or | (cr_hs[i] ? cr_resp_i[i] : 5'b0);
      lowest        = cd_pend[i] ? IdxW'(i) : lowest;
      data_o        = sel[i] ? cd_data_i[i] : data_o;
      cd_ready_o[i] = state == SNP_DATA && cd_pend[i] && (sel[i] ? data_ready_i : 1'b1);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= SNP_IDLE;
      ac_pend <= '0;
      cr_pend <= '0;
      cd_pend <= '0;
      resp    <= '0;
      src     <= '0;
      cnt     <= '0;
      addr    <= '0;
      snoop   <= '0;
      prot    <= '0;
    end else begin
      case (state)
        SNP_IDLE: if (snp_valid_i) begin
          addr    <= snp_addr_i;
          snoop   <= snp_type_i;
          prot    <= snp_prot_i;
          ac_pend <= tgt_mask;
          cr_pend <= tgt_mask;
          cd_pend <= '0;
          resp    <= '0;
          src     <= '0;
          cnt     <= '0;
          state   <= |tgt_mask ? SNP_SNOOP : SNP_RESP;
        end
        SNP_SNOOP: begin
          ac_pend <= ac_pend & ~(ac_valid_o & ac_ready_i);
          cr_pend <= cr_pend & ~cr_hs;
          cd_pend <= cd_pend | (cr_hs & cr_dt);
          resp    <= resp | cr_or;
          if (!(|ac_pend) && !(|cr_pend)) begin
            src   <= lowest;
            state <= SNP_RESP;
          end
        end
        SNP_RESP: if (res_ready_i) state <= |cd_pend ? SNP_DATA : SNP_IDLE;
        SNP_DATA: begin
          cd_pend <= cd_pend & ~cd_done;
          if (fwd_hs) cnt <= cnt_last ? '0 : cnt + 1'b1;
          if (!(|cd_pend)) state <= SNP_IDLE;
        end
        default: state <= SNP_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccu_snoop_broadcaster.sv
// tb_ccu_snoop_broadcaster: master models plus a result/data scoreboard around the broadcaster
module tb_ccu_snoop_broadcaster;
  localparam int N = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic snp_valid, snp_ready;
  logic [63:0] snp_addr;
  logic [3:0] snp_type;
  logic [2:0] snp_prot;
  logic [1:0] snp_init;
  logic [N-1:0] ac_valid, ac_ready, cr_valid, cr_ready, cd_valid, cd_ready, cd_last;
  logic [63:0] ac_addr;
  logic [3:0] ac_snoop;
  logic [2:0] ac_prot;
  logic [N-1:0][4:0] cr_resp;
  logic [N-1:0][63:0] cd_data;
  logic res_valid, res_ready, data_valid, data_ready, data_last;
  logic [4:0] res_resp;
  logic [1:0] res_src;
  logic [63:0] data;
  logic one_valid, one_snp_ready, one_init, one_ac_valid, one_ac_ready, one_cr_valid, one_cr_ready;
  logic one_cd_ready, one_res_valid, one_res_ready, one_res_src, one_data_valid, one_data_last;
  logic [15:0] one_ac_addr;
  logic [3:0] one_ac_snoop;
  logic [2:0] one_ac_prot;
  logic [0:0][4:0] one_cr_resp;
  logic [0:0][31:0] one_cd_data;
  logic [4:0] one_res_resp;
  logic [31:0] one_data;
  ccu_snoop_broadcaster u_dut (
    .clk_i(clk), .rst_ni(rst_n), .snp_valid_i(snp_valid), .snp_ready_o(snp_ready),
    .snp_addr_i(snp_addr), .snp_type_i(snp_type), .snp_prot_i(snp_prot), .snp_init_i(snp_init),
    .ac_valid_o(ac_valid), .ac_ready_i(ac_ready), .ac_addr_o(ac_addr), .ac_snoop_o(ac_snoop),
    .ac_prot_o(ac_prot), .cr_valid_i(cr_valid), .cr_ready_o(cr_ready), .cr_resp_i(cr_resp),
    .cd_valid_i(cd_valid), .cd_ready_o(cd_ready), .cd_data_i(cd_data), .cd_last_i(cd_last),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_resp_o(res_resp), .res_src_o(res_src),
    .data_valid_o(data_valid), .data_ready_i(data_ready), .data_o(data), .data_last_o(data_last)
  );
  ccu_snoop_broadcaster #(.NoMstPorts(1), .AddrWidth(16), .DataWidth(32), .DcacheLineWidth(32)) u_one (
    .clk_i(clk), .rst_ni(rst_n), .snp_valid_i(one_valid), .snp_ready_o(one_snp_ready),
    .snp_addr_i(16'h1234), .snp_type_i(4'h1), .snp_prot_i(3'h2), .snp_init_i(one_init),
    .ac_valid_o(one_ac_valid), .ac_ready_i(one_ac_ready), .ac_addr_o(one_ac_addr),
    .ac_snoop_o(one_ac_snoop), .ac_prot_o(one_ac_prot), .cr_valid_i(one_cr_valid),
    .cr_ready_o(one_cr_ready), .cr_resp_i(one_cr_resp), .cd_valid_i(1'b0), .cd_ready_o(one_cd_ready),
    .cd_data_i(one_cd_data), .cd_last_i(1'b0), .res_valid_o(one_res_valid),
    .res_ready_i(one_res_ready), .res_resp_o(one_res_resp), .res_src_o(one_res_src),
    .data_valid_o(one_data_valid), .data_ready_i(1'b1), .data_o(one_data), .data_last_o(one_data_last)
  );
  int p = 0, t = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    t++;
    if (got === exp) p++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  int ac_delay[N];
  logic [4:0] crv[N];
  bit cr_early[N];
  logic [63:0] bt[N][2];
  bit rnd_dr;
  int epoch = 0;
  logic [6:0] exp_tp;
  logic [63:0] exp_addr;
  logic [6:0] exp_res[$];
  logic [64:0] exp_data[$];
  // Master model: snapshots handshakes on negedge, reacts just after posedge
  logic [N-1:0] s_ac_v, s_ac_hs, s_cr_hs, s_cd_hs, p_ac_v, p_ac_r;
  int ac_wait[N], bidx[N];
  bit ac_done[N], cr_done[N], cd_act[N];
  int seen = 0;
  always @(posedge clk) begin
    #1;
    if (seen != epoch) begin
      seen = epoch;
      for (int i = 0; i < N; i++) begin
        ac_wait[i] = 0; bidx[i] = 0; ac_done[i] = 0; cr_done[i] = 0; cd_act[i] = 0;
      end
      s_ac_v = '0; s_ac_hs = '0; s_cr_hs = '0; s_cd_hs = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (s_ac_v[i] && !s_ac_hs[i]) ac_wait[i]++;
      if (s_ac_hs[i]) ac_done[i] = 1;
      if (s_cr_hs[i]) begin
        cr_done[i] = 1;
        if (crv[i][0]) begin cd_act[i] = 1; bidx[i] = 0; end
      end
      if (s_cd_hs[i]) begin bidx[i]++; if (bidx[i] == 2) cd_act[i] = 0; end
      ac_ready[i] = ac_valid[i] && ac_wait[i] >= ac_delay[i];
      cr_valid[i] = !cr_done[i] && (ac_done[i] || (cr_early[i] && ac_valid[i]));
      cr_resp[i]  = crv[i];
      cd_valid[i] = cd_act[i];
      cd_data[i]  = bt[i][bidx[i] & 1];
      cd_last[i]  = bidx[i] == 1;
    end
    data_ready = rnd_dr ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    s_ac_v = ac_valid; s_ac_hs = ac_valid & ac_ready;
    s_cr_hs = cr_valid & cr_ready; s_cd_hs = cd_valid & cd_ready;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (p_ac_v[i] && !p_ac_r[i]) check("ac_stable", ac_valid[i], 1);
        if (cr_valid[i] && ac_valid[i]) check("cr_hold", cr_ready[i], 0);
      end
      if (|ac_valid) begin
        check("ac_addr", ac_addr, exp_addr);
        check("ac_type", {ac_prot, ac_snoop}, exp_tp);
      end
      if (|cd_valid) check("cd_drain", snp_ready, 0);
      if (res_valid) check("cd_held", cd_ready, 0);
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) check("res_extra", 1, 0);
        else begin
          logic [6:0] r;
          r = exp_res.pop_front();
          check("res_resp", res_resp, r[6:2]);
          check("res_src", res_src, r[1:0]);
        end
      end
      if (data_valid && data_ready) begin
        if (exp_data.size() == 0) check("data_extra", data, 0);
        else begin
          logic [64:0] d;
          d = exp_data.pop_front();
          check("data", data, d[64:1]);
          check("data_last", data_last, d[0]);
        end
      end
    end
    p_ac_v = ac_valid; p_ac_r = ac_ready;
  end
  task automatic clr_cfg();
    for (int i = 0; i < N; i++) begin
      ac_delay[i] = 0; crv[i] = '0; cr_early[i] = 0;
      bt[i][0] = 64'h100 + 64'(i); bt[i][1] = 64'h200 + 64'(i);
    end
    rnd_dr = 0;
  endtask
  task automatic start(input logic [1:0] init, input logic [3:0] mask, input logic [4:0] er,
                       input logic [1:0] es, input int src);
    @(negedge clk); #1;
    epoch++;
    exp_addr = {$urandom, $urandom};
    exp_tp = 7'($urandom);
    snp_addr = exp_addr;
    {snp_prot, snp_type} = exp_tp;
    snp_init = init;
    snp_valid = 1;
    exp_res.push_back({er, es});
    if (er[0]) for (int b = 0; b < 2; b++) exp_data.push_back({bt[src][b], b == 1});
    @(posedge clk); #1;
    snp_valid = 0;
    check("ac_fanout", ac_valid, mask);
  endtask
  task automatic finish(input bit lat);
    int n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (lat) check("latency", n, 3);
    n = 0;
    while (!(snp_ready && exp_res.size() == 0 && exp_data.size() == 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("done", n < 200, 1);
  endtask
  initial begin
    int n;
    snp_valid = 0; snp_addr = '0; snp_type = '0; snp_prot = '0; snp_init = '0; res_ready = 1;
    ac_ready = '0; cr_valid = '0; cr_resp = '0; cd_valid = '0; cd_data = '0; cd_last = '0;
    data_ready = 1; one_valid = 0; one_init = 0; one_ac_ready = 0; one_cr_valid = 0;
    one_cr_resp = '0; one_cd_data = '0; one_res_ready = 0; exp_addr = '0; exp_tp = '0;
    p_ac_v = '0; p_ac_r = '0;
    clr_cfg();
    repeat (3) @(negedge clk);
    check("rst_idle", {snp_ready, ac_valid, cr_ready, cd_ready, res_valid, data_valid}, 15'h4000);
    check("rst_one", {one_snp_ready, one_res_valid, one_ac_valid}, 3'b100);
    rst_n = 1;
    // plain fan-out, no data
    start(2'd1, 4'b1101, 5'b00000, 2'd0, 0);
    finish(1);
    // single supplier, two-beat line
    clr_cfg(); crv[2] = 5'b00101; bt[2][0] = 64'hA; bt[2][1] = 64'hB;
    start(2'd0, 4'b1110, 5'b00101, 2'd2, 2);
    finish(1);
    // two suppliers: lowest forwarded, other drained
    clr_cfg(); crv[1] = 5'b01001; crv[3] = 5'b01001; rnd_dr = 1;
    bt[1][0] = 64'h1111; bt[1][1] = 64'h2222; bt[3][0] = 64'h3333; bt[3][1] = 64'h4444;
    start(2'd0, 4'b1110, 5'b01001, 2'd1, 1);
    finish(0);
    // late AC ready on port3 with early CR
    clr_cfg(); ac_delay[3] = 5; cr_early[3] = 1; crv[1] = 5'b10000; crv[3] = 5'b00010;
    start(2'd0, 4'b1110, 5'b10010, 2'd0, 0);
    finish(0);
    // single-port instance: no AC, immediate result held under backpressure
    @(negedge clk); one_init = 0; one_valid = 1;
    @(posedge clk); #1 one_valid = 0;
    check("one_res_valid", one_res_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("one_hold", {one_res_valid, one_res_resp, one_res_src, one_ac_valid}, 8'h80);
    end
    one_res_ready = 1;
    @(posedge clk); #1 one_res_ready = 0;
    check("one_idle", {one_snp_ready, one_res_valid}, 2'b10);
    // out-of-range initiator excludes nobody
    @(negedge clk); one_init = 1; one_valid = 1;
    @(posedge clk); #1 one_valid = 0;
    check("one_fanout", one_ac_valid, 1);
    check("one_addr", {one_ac_addr, one_ac_snoop, one_ac_prot}, {16'h1234, 4'h1, 3'h2});
    one_ac_ready = 1;
    @(posedge clk); #1 one_ac_ready = 0; one_cr_valid = 1; one_cr_resp = 5'b10000;
    check("one_cr_ready", one_cr_ready, 1);
    @(posedge clk); #1 one_cr_valid = 0;
    n = 0;
    while (!one_res_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("one_resp", one_res_resp, 5'b10000);
    one_res_ready = 1;
    @(posedge clk); #1 one_res_ready = 0;
    // async reset in the middle of a line
    clr_cfg(); crv[2] = 5'b00101; bt[2][0] = 64'hC0; bt[2][1] = 64'hC1;
    start(2'd0, 4'b1110, 5'b00101, 2'd2, 2);
    n = 0;
    while (!(data_valid && data_ready) && n < 100) begin @(negedge clk); n++; end
    check("rst_reach_data", n < 100, 1);
    @(posedge clk); #3 rst_n = 0;
    #1;
    check("rst_async", {snp_ready, ac_valid, cr_ready, cd_ready, res_valid, data_valid}, 15'h4000);
    exp_res.delete(); exp_data.delete(); epoch++;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 check("rst_release", snp_ready, 1);
    clr_cfg();
    start(2'd3, 4'b0111, 5'b00000, 2'd0, 0);
    finish(1);
    $display("%0d/%0d checks passed", p, t);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
